// File: rtl/console_pkg.sv
// Shared constants, op-codes and state encoding for the text console engine.
// Screen geometry is fixed here; COLS*ROWS must stay <= 2048.
package console_pkg;

    localparam int COLS = 80;
    localparam int ROWS = 25;
    localparam logic [7:0] BLANK_CHAR = 8'h20;

    localparam int CELLS = COLS * ROWS;
    localparam int ROW_BYTES = 2 * COLS;
    localparam int SCR_BYTES = ROW_BYTES * (ROWS - 1);
    localparam int SCREEN_BYTES = 2 * CELLS;

    localparam logic [10:0] LAST_CELL = 11'(CELLS - 1);
    localparam logic [10:0] LAST_ROW_START = 11'((ROWS - 1) * COLS);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [11:0] SCR_LAST = 12'(SCR_BYTES - 1);
    localparam logic [11:0] SCREEN_LAST = 12'(SCREEN_BYTES - 1);
    localparam logic [11:0] ROW_OFS = 12'(ROW_BYTES);

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_PUTC = 3'd1;
    localparam logic [2:0] OP_NEWLINE = 3'd2;
    localparam logic [2:0] OP_CLEAR = 3'd3;
    localparam logic [2:0] OP_SCROLL = 3'd4;
    localparam logic [2:0] OP_SETCUR = 3'd5;
    localparam logic [2:0] OP_BKSP = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUT_CH,
        S_PUT_AT,
        S_CLR,
        S_SC_RD,
        S_SC_WR,
        S_SC_FILL,
        S_BK_CH
    } state_t;

    // Row of an arbitrary cell index via a compare chain (no divider).
    function automatic logic [4:0] row_of(logic [10:0] c);
        logic [4:0] r;
        r = '0;
        for (int k = 1; k < ROWS; k++) begin
            if (int'(c) >= k * COLS) r = r + 5'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vram_port_arb.sv
// Shares the single VRAM port between Z80 accesses and the console engine.
// The CPU wins unless it was granted last cycle, so the engine gets >= 1/2.
module vram_port_arb (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [11:0] cpu_addr_i,
    input  logic [7:0]  cpu_wdata_i,
    output logic        cpu_ack_o,
    output logic [7:0]  cpu_rdata_o,
    input  logic        eng_req_i,
    input  logic        eng_we_i,
    input  logic [11:0] eng_addr_i,
    input  logic [7:0]  eng_wdata_i,
    output logic        eng_gnt_o,
    output logic [11:0] ram_addr_o,
    output logic [7:0]  ram_wdata_o,
    output logic        ram_we_o,
    input  logic [7:0]  ram_rdata_i
);

    logic cpu_gnt;
    logic gnt_q;

    // Reset gates the grant so the port is quiet while reset is held.
    assign cpu_gnt = rst_ni & cpu_req_i & ~gnt_q;
    assign eng_gnt_o = eng_req_i & ~cpu_gnt;
    assign cpu_ack_o = gnt_q;
    assign cpu_rdata_o = gnt_q ? ram_rdata_i : 8'h00;

    // Remember last cycle's CPU grant; it is also the ack pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) gnt_q <= 1'b0;
        else gnt_q <= cpu_gnt;
    end

    // Drive the RAM port from whichever side owns this cycle.
    always_comb begin
        ram_addr_o = '0;
        ram_wdata_o = '0;
        ram_we_o = 1'b0;
        if (cpu_gnt) begin
            ram_addr_o = cpu_addr_i;
            ram_wdata_o = cpu_wdata_i;
            ram_we_o = cpu_we_i;
        end else if (eng_gnt_o) begin
            ram_addr_o = eng_addr_i;
            ram_wdata_o = eng_wdata_i;
            ram_we_o = eng_we_i;
        end
    end

endmodule

// File: rtl/text_console_ctrl.sv
// 80x25 text console engine: executes console commands on the VRAM and
// tracks the cursor, sharing the RAM port with direct Z80 accesses.
module text_console_ctrl
    import console_pkg::*;
(
    input  logic        clock_25,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_data,
    input  logic [7:0]  cmd_attr,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [11:0] cpu_address,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic [11:0] ram_address,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata,
    output logic [10:0] cursor,
    output logic        busy
);

    state_t state_q, state_d;
    logic [10:0] cursor_q, cursor_d;
    logic [4:0] row_q, row_d;
    logic [6:0] col_q, col_d;
    logic [11:0] idx_q, idx_d;
    logic [7:0] char_q, char_d;
    logic [7:0] attr_q, attr_d;
    logic tail_q, tail_d;
    logic rd_pend_q;
    logic [7:0] hold_q;

    logic eng_req, eng_we, eng_gnt;
    logic [11:0] eng_addr;
    logic [7:0] eng_wdata;
    logic [10:0] set_v;

    assign set_v = {cmd_attr[2:0], cmd_data};
    assign cmd_ready = reset_n & (state_q == S_IDLE);
    assign busy = (state_q != S_IDLE);
    assign cursor = cursor_q;

    vram_port_arb u_arb (
        .clk_i       (clock_25),
        .rst_ni      (reset_n),
        .cpu_req_i   (cpu_req),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_address),
        .cpu_wdata_i (cpu_wdata),
        .cpu_ack_o   (cpu_ack),
        .cpu_rdata_o (cpu_rdata),
        .eng_req_i   (eng_req),
        .eng_we_i    (eng_we),
        .eng_addr_i  (eng_addr),
        .eng_wdata_i (eng_wdata),
        .eng_gnt_o   (eng_gnt),
        .ram_addr_o  (ram_address),
        .ram_wdata_o (ram_wdata),
        .ram_we_o    (ram_we),
        .ram_rdata_i (ram_rdata)
    );

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cursor_q <= '0;
            row_q <= '0;
            col_q <= '0;
            idx_q <= '0;
            char_q <= '0;
            attr_q <= '0;
            tail_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cursor_q <= cursor_d;
            row_q <= row_d;
            col_q <= col_d;
            idx_q <= idx_d;
            char_q <= char_d;
            attr_q <= attr_d;
            tail_q <= tail_d;
        end
    end

    // Scroll read data lands the cycle after its grant, even if the CPU owns it.
    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_q <= 1'b0;
            hold_q <= '0;
        end else begin
            rd_pend_q <= (state_q == S_SC_RD) & eng_gnt;
            if (rd_pend_q) hold_q <= ram_rdata;
        end
    end

    // Next state, cursor/row/col bookkeeping; RAM steps advance only on grant.
    always_comb begin
        state_d = state_q;
        cursor_d = cursor_q;
        row_d = row_q;
        col_d = col_q;
        idx_d = idx_q;
        char_d = char_q;
        attr_d = attr_q;
        tail_d = tail_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    char_d = cmd_data;
                    attr_d = cmd_attr;
                    idx_d = '0;
                    unique case (cmd_op)
                        OP_PUTC: state_d = S_PUT_CH;
                        OP_NEWLINE: begin
                            if (row_q == LAST_ROW) begin
                                state_d = S_SC_RD;
                                tail_d = 1'b1;
                            end else begin
                                cursor_d = cursor_q - 11'(col_q) + 11'(COLS);
                                row_d = row_q + 5'd1;
                                col_d = '0;
                            end
                        end
                        OP_CLEAR: state_d = S_CLR;
                        OP_SCROLL: begin
                            state_d = S_SC_RD;
                            tail_d = 1'b0;
                        end
                        OP_SETCUR: begin
                            cursor_d = (set_v > LAST_CELL) ? LAST_CELL : set_v;
                            row_d = row_of(cursor_d);
                            col_d = 7'(cursor_d - 11'(row_d) * 11'(COLS));
                        end
                        OP_BKSP: begin
                            if (cursor_q != '0) begin
                                cursor_d = cursor_q - 11'd1;
                                if (col_q == '0) begin
                                    row_d = row_q - 5'd1;
                                    col_d = LAST_COL;
                                end else begin
                                    col_d = col_q - 7'd1;
                                end
                                state_d = S_BK_CH;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_PUT_CH: if (eng_gnt) state_d = S_PUT_AT;
            S_PUT_AT: begin
                if (eng_gnt) begin
                    if (cursor_q == LAST_CELL) begin
                        state_d = S_SC_RD;
                        tail_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        cursor_d = cursor_q + 11'd1;
                        if (col_q == LAST_COL) begin
                            col_d = '0;
                            row_d = row_q + 5'd1;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end
                end
            end
            S_CLR: begin
                if (eng_gnt) begin
                    idx_d = idx_q + 12'd1;
                    if (idx_q == SCREEN_LAST) begin
                        state_d = S_IDLE;
                        cursor_d = '0;
                        row_d = '0;
                        col_d = '0;
                    end
                end
            end
            S_SC_RD: if (eng_gnt) state_d = S_SC_WR;
            S_SC_WR: begin
                if (eng_gnt) begin
                    idx_d = idx_q + 12'd1;
                    state_d = (idx_q == SCR_LAST) ? S_SC_FILL : S_SC_RD;
                end
            end
            S_SC_FILL: begin
                if (eng_gnt) begin
                    idx_d = idx_q + 12'd1;
                    if (idx_q == SCREEN_LAST) begin
                        state_d = S_IDLE;
                        if (tail_q) begin
                            cursor_d = LAST_ROW_START;
                            row_d = LAST_ROW;
                            col_d = '0;
                        end
                    end
                end
            end
            S_BK_CH: if (eng_gnt) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Engine side of the RAM port for the current step.
    always_comb begin
        eng_req = (state_q != S_IDLE);
        eng_we = (state_q != S_SC_RD);
        eng_addr = '0;
        eng_wdata = '0;
        unique case (state_q)
            S_PUT_CH: begin
                eng_addr = {cursor_q, 1'b0};
                eng_wdata = char_q;
            end
            S_PUT_AT: begin
                eng_addr = {cursor_q, 1'b1};
                eng_wdata = attr_q;
            end
            S_CLR, S_SC_FILL: begin
                eng_addr = idx_q;
                eng_wdata = idx_q[0] ? attr_q : BLANK_CHAR;
            end
            S_SC_RD: eng_addr = idx_q + ROW_OFS;
            S_SC_WR: begin
                eng_addr = idx_q;
                eng_wdata = rd_pend_q ? ram_rdata : hold_q;
            end
            S_BK_CH: begin
                eng_addr = {cursor_q, 1'b0};
                eng_wdata = BLANK_CHAR;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Bench for text_console_ctrl: behavioural screen model plus VRAM model,
// with randomized characters, attributes, cursors and command streams.
`timescale 1ns/1ps
module tb_text_console_ctrl;

    localparam int W = 80;
    localparam int H = 25;
    localparam int N = W * H;
    localparam logic [2:0] P_NOP = 3'd0;
    localparam logic [2:0] P_PUTC = 3'd1;
    localparam logic [2:0] P_NL = 3'd2;
    localparam logic [2:0] P_CLR = 3'd3;
    localparam logic [2:0] P_SCR = 3'd4;
    localparam logic [2:0] P_SET = 3'd5;
    localparam logic [2:0] P_BK = 3'd6;
    localparam logic [2:0] P_RSV = 3'd7;

    logic clock_25 = 1'b0;
    logic reset_n = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [7:0] cmd_data = '0;
    logic [7:0] cmd_attr = '0;
    logic cpu_req = 1'b0;
    logic cpu_we = 1'b0;
    logic [11:0] cpu_address = '0;
    logic [7:0] cpu_wdata = '0;
    logic cpu_ack;
    logic [7:0] cpu_rdata;
    logic [11:0] ram_address;
    logic [7:0] ram_wdata;
    logic ram_we;
    logic [7:0] ram_rdata;
    logic [10:0] cursor;
    logic busy;

    int total = 0;
    int bad = 0;

    always #5 clock_25 = ~clock_25;

    text_console_ctrl dut (
        .clock_25    (clock_25),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .cmd_attr    (cmd_attr),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_address (cpu_address),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .ram_address (ram_address),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we),
        .ram_rdata   (ram_rdata),
        .cursor      (cursor),
        .busy        (busy)
    );

    logic [7:0] mem [4096];
    logic [7:0] rd_q;
    int we_cnt = 0;

    always @(posedge clock_25) begin
        if (ram_we) begin
            mem[ram_address] <= ram_wdata;
            we_cnt <= we_cnt + 1;
        end
        rd_q <= mem[ram_address];
    end
    assign ram_rdata = rd_q;

    logic [7:0] exp_mem [4096];
    int exp_cur = 0;

    function automatic void m_scroll(logic [7:0] a);
        for (int b = 0; b < 2 * W * (H - 1); b++) exp_mem[b] = exp_mem[b + 2 * W];
        for (int b = 2 * W * (H - 1); b < 2 * N; b++)
            exp_mem[b] = (b % 2 == 0) ? 8'h20 : a;
    endfunction

    function automatic void m_putc(logic [7:0] c, logic [7:0] a);
        exp_mem[2 * exp_cur] = c;
        exp_mem[2 * exp_cur + 1] = a;
        exp_cur = exp_cur + 1;
        if (exp_cur == N) begin
            m_scroll(a);
            exp_cur = N - W;
        end
    endfunction

    function automatic void m_newline(logic [7:0] a);
        if (exp_cur / W == H - 1) begin
            m_scroll(a);
            exp_cur = N - W;
        end else begin
            exp_cur = (exp_cur / W + 1) * W;
        end
    endfunction

    function automatic void m_clear(logic [7:0] a);
        for (int b = 0; b < 2 * N; b++) exp_mem[b] = (b % 2 == 0) ? 8'h20 : a;
        exp_cur = 0;
    endfunction

    function automatic void m_setcur(int v);
        exp_cur = (v > N - 1) ? N - 1 : v;
    endfunction

    function automatic void m_bksp();
        if (exp_cur > 0) begin
            exp_cur = exp_cur - 1;
            exp_mem[2 * exp_cur] = 8'h20;
        end
    endfunction

    function automatic int img_diff();
        int d = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== exp_mem[i]) d++;
        return d;
    endfunction

    task automatic tick();
        @(posedge clock_25);
        #1;
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [7:0] d,
                          input logic [7:0] a, output int cyc);
        cyc = 0;
        while (!cmd_ready && cyc < 20000) begin
            tick();
            cyc++;
        end
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_data = d;
        cmd_attr = a;
        tick();
        cmd_valid = 1'b0;
        cyc = 1;
        while (!cmd_ready && cyc < 20000) begin
            tick();
            cyc++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL cmd_timeout op=%0d got_ready=%b want=1", op, cmd_ready);
        end
    endtask

    task automatic set_cur(input int v);
        int cyc;
        logic [10:0] vv;
        logic [7:0] hi;
        vv = 11'(v);
        hi = 8'($urandom);
        do_cmd(P_SET, vv[7:0], {hi[7:3], vv[10:8]}, cyc);
        m_setcur(v);
    endtask

    task automatic cpu_rw(input logic we, input logic [11:0] ad,
                          input logic [7:0] wd, output logic [7:0] rd,
                          output int lat);
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_address = ad;
        cpu_wdata = wd;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!cpu_ack && lat < 10);
        rd = cpu_rdata;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_address = 12'hABC;
        cpu_wdata = 8'h55;
        #3;
        total++;
        if ({cmd_ready, busy, cursor, cpu_ack, cpu_rdata, ram_we, ram_address, ram_wdata} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got we=%b addr=%h wd=%h cur=%0d busy=%b want all 0",
                     ram_we, ram_address, ram_wdata, cursor, busy);
        end
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        repeat (3) @(posedge clock_25);
        #1;
        reset_n = 1'b1;
        tick();
        total++;
        if (cmd_ready !== 1'b1 || cursor !== 11'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got ready=%b cur=%0d busy=%b want 1/0/0",
                     cmd_ready, cursor, busy);
        end
    endtask

    task automatic test_putc_basic();
        int cyc;
        do_cmd(P_PUTC, 8'h41, 8'h1F, cyc);
        m_putc(8'h41, 8'h1F);
        total++;
        if (cyc !== 3) begin
            bad++;
            $display("FAIL putc_latency got=%0d want=3", cyc);
        end
        total++;
        if (mem[0] !== 8'h41 || mem[1] !== 8'h1F) begin
            bad++;
            $display("FAIL putc_bytes got=%h/%h want=41/1f", mem[0], mem[1]);
        end
        total++;
        if (cursor !== 11'd1) begin
            bad++;
            $display("FAIL putc_cursor got=%0d want=1", cursor);
        end
    endtask

    task automatic test_setcur();
        int v;
        set_cur(2047);
        total++;
        if (cursor !== 11'(exp_cur)) begin
            bad++;
            $display("FAIL setcur_clamp2047 got=%0d want=%0d", cursor, exp_cur);
        end
        set_cur(2000);
        total++;
        if (cursor !== 11'(exp_cur)) begin
            bad++;
            $display("FAIL setcur_clamp2000 got=%0d want=%0d", cursor, exp_cur);
        end
        v = $urandom_range(0, N - 1);
        set_cur(v);
        total++;
        if (cursor !== 11'(exp_cur)) begin
            bad++;
            $display("FAIL setcur_rand got=%0d want=%0d", cursor, exp_cur);
        end
    endtask

    task automatic test_putc_scroll();
        int cyc;
        logic [7:0] a;
        a = 8'($urandom);
        set_cur(N - 1);
        do_cmd(P_PUTC, 8'h5A, a, cyc);
        m_putc(8'h5A, a);
        total++;
        if (mem[3838] !== 8'h5A) begin
            bad++;
            $display("FAIL putc_scroll_char got=%h want=5a", mem[3838]);
        end
        total++;
        if (cursor !== 11'(exp_cur)) begin
            bad++;
            $display("FAIL putc_scroll_cursor got=%0d want=%0d", cursor, exp_cur);
        end
        total++;
        if (img_diff() != 0) begin
            bad++;
            $display("FAIL putc_scroll_image got=%0d bad bytes want=0", img_diff());
        end
    endtask

    task automatic test_scroll_cmd();
        int cyc, c;
        logic [7:0] a;
        a = 8'($urandom);
        c = $urandom_range(0, N - 1);
        set_cur(c);
        do_cmd(P_SCR, 8'h00, a, cyc);
        m_scroll(a);
        total++;
        if (cyc !== 7841) begin
            bad++;
            $display("FAIL scroll_duration got=%0d want=7841", cyc);
        end
        total++;
        if (cursor !== 11'(exp_cur)) begin
            bad++;
            $display("FAIL scroll_cursor got=%0d want=%0d", cursor, exp_cur);
        end
        total++;
        if (img_diff() != 0) begin
            bad++;
            $display("FAIL scroll_image got=%0d bad bytes want=0", img_diff());
        end
    endtask

    task automatic test_clear_plain();
        int cyc;
        logic [7:0] a;
        a = 8'($urandom);
        do_cmd(P_CLR, 8'h00, a, cyc);
        m_clear(a);
        total++;
        if (cyc !== 4001) begin
            bad++;
            $display("FAIL clear_duration got=%0d want=4001", cyc);
        end
        total++;
        if (img_diff() != 0 || cursor !== 11'd0) begin
            bad++;
            $display("FAIL clear_image got=%0d bad bytes cur=%0d want=0/0", img_diff(), cursor);
        end
    endtask

    task automatic test_clear_contended();
        int cyc;
        bit done;
        done = 1'b0;
        set_cur(777);
        fork
            begin
                do_cmd(P_CLR, 8'h00, 8'h07, cyc);
                done = 1'b1;
            end
            begin
                int n;
                logic [11:0] ad;
                logic [7:0] rd;
                int lat;
                n = 0;
                while (!done && n < 10000) begin
                    ad = 12'($urandom_range(4000, 4095));
                    cpu_rw(1'b0, ad, 8'h00, rd, lat);
                    n++;
                    total++;
                    if (lat > 2 || rd !== exp_mem[ad]) begin
                        bad++;
                        $display("FAIL contend_read addr=%0d got=%h lat=%0d want=%h lat<=2",
                                 ad, rd, lat, exp_mem[ad]);
                    end
                end
            end
        join
        m_clear(8'h07);
        total++;
        if (cyc < 7900 || cyc > 8002) begin
            bad++;
            $display("FAIL contend_duration got=%0d want 7900..8002", cyc);
        end
        total++;
        if (img_diff() != 0 || cursor !== 11'd0) begin
            bad++;
            $display("FAIL contend_image got=%0d bad bytes cur=%0d want=0/0", img_diff(), cursor);
        end
    endtask

    task automatic test_cpu_rw();
        logic [11:0] ad;
        logic [7:0] wd, rd;
        int lat;
        for (int k = 0; k < 4; k++) begin
            ad = 12'($urandom);
            wd = 8'($urandom);
            cpu_rw(1'b1, ad, wd, rd, lat);
            exp_mem[ad] = wd;
            tick();
            cpu_rw(1'b0, ad, 8'h00, rd, lat);
            total++;
            if (rd !== wd || lat !== 1) begin
                bad++;
                $display("FAIL cpu_rw addr=%0d got=%h lat=%0d want=%h lat=1", ad, rd, lat, wd);
            end
            tick();
        end
    endtask

    task automatic test_newline();
        int cyc, w0;
        logic [7:0] a;
        set_cur(85);
        w0 = we_cnt;
        do_cmd(P_NL, 8'h00, 8'h00, cyc);
        m_newline(8'h00);
        total++;
        if (cursor !== 11'd160 || we_cnt != w0 || cyc != 1) begin
            bad++;
            $display("FAIL newline_mid got cur=%0d writes=%0d cyc=%0d want 160/0/1",
                     cursor, we_cnt - w0, cyc);
        end
        a = 8'($urandom);
        set_cur(1930);
        do_cmd(P_NL, 8'h00, a, cyc);
        m_newline(a);
        total++;
        if (cursor !== 11'd1920 || img_diff() != 0) begin
            bad++;
            $display("FAIL newline_scroll got cur=%0d bad=%0d want 1920/0", cursor, img_diff());
        end
    endtask

    task automatic test_bksp();
        int cyc, w0;
        set_cur(0);
        w0 = we_cnt;
        do_cmd(P_BK, 8'h00, 8'h00, cyc);
        m_bksp();
        total++;
        if (cursor !== 11'd0 || we_cnt != w0) begin
            bad++;
            $display("FAIL bksp_zero got cur=%0d writes=%0d want 0/0", cursor, we_cnt - w0);
        end
        set_cur(5);
        w0 = we_cnt;
        do_cmd(P_BK, 8'h00, 8'h00, cyc);
        m_bksp();
        total++;
        if (cursor !== 11'd4 || mem[8] !== 8'h20 || mem[9] !== exp_mem[9] || we_cnt != w0 + 1) begin
            bad++;
            $display("FAIL bksp_five got cur=%0d b8=%h b9=%h writes=%0d want 4/20/%h/1",
                     cursor, mem[8], mem[9], we_cnt - w0, exp_mem[9]);
        end
    endtask

    task automatic test_random();
        int cyc, r, v;
        logic [7:0] c, a;
        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(0, 9);
            c = 8'($urandom);
            a = 8'($urandom);
            if (r <= 3) begin
                do_cmd(P_PUTC, c, a, cyc);
                m_putc(c, a);
            end else if (r <= 5) begin
                do_cmd(P_NL, c, a, cyc);
                m_newline(a);
            end else if (r == 6) begin
                v = $urandom_range(0, 1500);
                set_cur(v);
            end else if (r <= 8) begin
                do_cmd(P_BK, c, a, cyc);
                m_bksp();
            end else begin
                do_cmd((k % 2 == 0) ? P_NOP : P_RSV, c, a, cyc);
            end
            total++;
            if (cursor !== 11'(exp_cur)) begin
                bad++;
                $display("FAIL random_cursor step=%0d got=%0d want=%0d", k, cursor, exp_cur);
            end
        end
        total++;
        if (img_diff() != 0) begin
            bad++;
            $display("FAIL random_image got=%0d bad bytes want=0", img_diff());
        end
    endtask

    task automatic test_reset_mid_scroll();
        int cyc;
        set_cur(1234);
        cmd_valid = 1'b1;
        cmd_op = P_SCR;
        cmd_data = 8'h00;
        cmd_attr = 8'h4E;
        tick();
        cmd_valid = 1'b0;
        repeat (1000) tick();
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({cmd_ready, busy, cursor, cpu_ack, cpu_rdata, ram_we, ram_address, ram_wdata} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got busy=%b cur=%0d we=%b addr=%h want all 0",
                     busy, cursor, ram_we, ram_address);
        end
        repeat (2) @(posedge clock_25);
        #1;
        reset_n = 1'b1;
        exp_cur = 0;
        tick();
        total++;
        if (cmd_ready !== 1'b1 || cursor !== 11'd0) begin
            bad++;
            $display("FAIL midreset_release got ready=%b cur=%0d want 1/0", cmd_ready, cursor);
        end
        do_cmd(P_CLR, 8'h00, 8'h07, cyc);
        m_clear(8'h07);
        do_cmd(P_PUTC, 8'h42, 8'h2A, cyc);
        m_putc(8'h42, 8'h2A);
        total++;
        if (mem[0] !== 8'h42 || mem[1] !== 8'h2A || cursor !== 11'd1 || img_diff() != 0) begin
            bad++;
            $display("FAIL midreset_putc got=%h/%h cur=%0d bad=%0d want 42/2a/1/0",
                     mem[0], mem[1], cursor, img_diff());
        end
    endtask

    initial begin
        logic [7:0] v;
        for (int i = 0; i < 4096; i++) begin
            v = 8'($urandom);
            mem[i] <= v;
            exp_mem[i] = v;
        end
        test_reset();
        test_putc_basic();
        test_setcur();
        test_putc_scroll();
        test_scroll_cmd();
        test_cpu_rw();
        test_newline();
        test_bksp();
        test_random();
        test_clear_plain();
        test_clear_contended();
        test_reset_mid_scroll();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
